// File: rtl/ram_responder.sv
// Single-port word memory behind a request/ready handshake with a fixed number of wait states.
// Accepts one read or write at a time and reports misaligned, out-of-range or ambiguous requests via ram_err.
module ram_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        nRST,
    input  logic        Ren,
    input  logic        Wen,
    input  logic [31:0] ramaddr,
    input  logic [31:0] ramstore,
    input  logic [3:0]  byte_en,
    output logic [31:0] ramload,
    output logic        ram_ready,
    output logic        ram_busy,
    output logic        ram_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(LATENCY + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [31:0]     data_q, data_d;
    logic [3:0]      be_q, be_d;
    logic            wr_q, wr_d;
    logic            bad_q, bad_d;
    logic            ready_q, ready_d;
    logic            busy_q, busy_d;
    logic            rerr_q, rerr_d;
    logic            rvalid_q, rvalid_d;

    logic [AW-1:0]   in_idx, op_idx;
    logic [31:0]     op_data;
    logic [3:0]      op_be;
    logic            in_bad, op_wr, op_bad;
    logic            access, mem_we, mem_re;

    assign in_idx = ramaddr[AW+1:2];
    assign in_bad = (ramaddr[1:0] != 2'b00) || (|ramaddr[31:AW+2]) || (Ren && Wen);

    // With LATENCY=1 the access happens on the accepting edge, so operands come straight from the port.
    always_comb begin
        if (state_q == IDLE) begin
            op_idx  = in_idx;
            op_data = ramstore;
            op_be   = byte_en;
            op_wr   = Wen;
            op_bad  = in_bad;
        end else begin
            op_idx  = idx_q;
            op_data = data_q;
            op_be   = be_q;
            op_wr   = wr_q;
            op_bad  = bad_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        data_d  = data_q;
        be_d    = be_q;
        wr_d    = wr_q;
        bad_d   = bad_q;
        access  = 1'b0;
        case (state_q)
            IDLE: begin
                if (Ren || Wen) begin
                    idx_d  = in_idx;
                    data_d = ramstore;
                    be_d   = byte_en;
                    wr_d   = Wen;
                    bad_d  = in_bad;
                    cnt_d  = CNT_LOAD;
                    if (LATENCY == 1) begin
                        access  = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                // The access fires on the edge that brings the counter to zero.
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    access  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ready_d  = access;
        busy_d   = (state_d != IDLE);
        rerr_d   = access && op_bad;
        rvalid_d = access && !op_wr && !op_bad;
    end

    assign mem_we = access && op_wr && !op_bad && nRST;
    assign mem_re = access && !op_wr && !op_bad && nRST;

    always_ff @(posedge clk) begin
        if (!nRST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            data_q   <= '0;
            be_q     <= '0;
            wr_q     <= 1'b0;
            bad_q    <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            rerr_q   <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            be_q     <= be_d;
            wr_q     <= wr_d;
            bad_q    <= bad_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            rerr_q   <= rerr_d;
            rvalid_q <= rvalid_d;
        end
    end

    // One byte-wide RAM per lane so byte enables map onto independent write ports.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] rd_byte_q;
            always_ff @(posedge clk) begin
                if (mem_we && op_be[gi]) begin
                    lane_mem[op_idx] <= op_data[8*gi +: 8];
                end
                if (mem_re) begin
                    rd_byte_q <= lane_mem[op_idx];
                end
            end
            assign ramload[8*gi +: 8] = rvalid_q ? rd_byte_q : 8'h00;
        end
    endgenerate

    assign ram_ready = ready_q;
    assign ram_busy  = busy_q;
    assign ram_err   = rerr_q;
endmodule
